// File: rtl/datapath_unit.sv
// Multi-cycle processor datapath: register file, PC, IR, ALU with A/G registers,
// memory address/data registers and a 4:1 shared bus, steered by control strobes.
module datapath_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] DIN,
    input  logic              IR_in,
    input  logic              ADDR_in,
    input  logic              DOUT_in,
    input  logic              W_D,
    input  logic              G_in,
    input  logic              A_in,
    input  logic              incr_PC,
    input  logic              PC_in,
    input  logic [1:0]        mux_control,
    input  logic [3:0]        ULA_control,
    input  logic [6:0]        register_in,
    input  logic [2:0]        register_out,
    output logic [9:0]        IR,
    output logic              G_or,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DOUT,
    output logic              W,
    output logic [DATA_W-1:0] bus
);

    localparam logic [1:0] SEL_DIN = 2'b00;
    localparam logic [1:0] SEL_REG = 2'b01;
    localparam logic [1:0] SEL_PC  = 2'b10;
    localparam logic [1:0] SEL_G   = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;

    logic [DATA_W-1:0] r [0:6];
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] reg_rd;
    logic [DATA_W-1:0] alu;
    logic              slt;

    // Select 7 has no backing register and reads as zero.
    always_comb begin
        reg_rd = '0;
        case (register_out)
            3'd0:    reg_rd = r[0];
            3'd1:    reg_rd = r[1];
            3'd2:    reg_rd = r[2];
            3'd3:    reg_rd = r[3];
            3'd4:    reg_rd = r[4];
            3'd5:    reg_rd = r[5];
            3'd6:    reg_rd = r[6];
            default: reg_rd = '0;
        endcase
    end

    always_comb begin
        bus = '0;
        case (mux_control)
            SEL_DIN: bus = DIN;
            SEL_REG: bus = reg_rd;
            SEL_PC:  bus = pc;
            SEL_G:   bus = g;
            default: bus = '0;
        endcase
    end

    assign slt = ($signed(a) < $signed(bus));

    // Shifts use only the low four bits of the bus as the shift amount.
    always_comb begin
        alu = bus;
        case (ULA_control)
            OP_ADD:  alu = a + bus;
            OP_SUB:  alu = a - bus;
            OP_OR:   alu = a | bus;
            OP_SLT:  alu = {{(DATA_W-1){1'b0}}, slt};
            OP_SLL:  alu = a << bus[3:0];
            OP_SRL:  alu = a >> bus[3:0];
            default: alu = bus;
        endcase
    end

    assign G_or = |g;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) r[i] <= '0;
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (register_in[i]) r[i] <= bus;
            end
        end
    end

    // Every target samples the same pre-edge bus, so simultaneous strobes are independent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc   <= '0;
            IR   <= '0;
            a    <= '0;
            g    <= '0;
            ADDR <= '0;
            DOUT <= '0;
            W    <= 1'b0;
        end else begin
            if (PC_in)        pc <= bus;
            else if (incr_PC) pc <= pc + 1'b1;
            if (IR_in)   IR   <= DIN[9:0];
            if (A_in)    a    <= bus;
            if (G_in)    g    <= alu;
            if (ADDR_in) ADDR <= bus[ADDR_W-1:0];
            if (DOUT_in) DOUT <= bus;
            W <= W_D;
        end
    end

endmodule

// File: tb/tb_datapath_unit.sv
// Bench for datapath_unit: directed test-plan sequences plus random strobes,
// checked each cycle against a behavioural model through an expected-output queue.
module tb_datapath_unit;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int EXP_W = 10 + 1 + AW + DW + 1 + DW;

    typedef struct packed {
        logic [DW-1:0] din;
        logic          ir_in;
        logic          addr_in;
        logic          dout_in;
        logic          w_d;
        logic          g_in;
        logic          a_in;
        logic          incr_pc;
        logic          pc_in;
        logic [1:0]    mux;
        logic [3:0]    ula;
        logic [6:0]    rin;
        logic [2:0]    rout;
    } stim_t;

    logic          clock;
    logic          reset;
    logic [DW-1:0] din;
    logic          ir_in, addr_in, dout_in, w_d, g_in, a_in, incr_pc, pc_in;
    logic [1:0]    mux_control;
    logic [3:0]    ula_control;
    logic [6:0]    register_in;
    logic [2:0]    register_out;
    logic [9:0]    ir;
    logic          g_or;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          w;
    logic [DW-1:0] bus;

    int checks   = 0;
    int failures = 0;

    logic [EXP_W-1:0] exp_q[$];

    // Behavioural model state; index 7 is the absent register and stays zero.
    logic [DW-1:0] m_r [0:7];
    logic [DW-1:0] m_pc, m_a, m_g, m_dout;
    logic [9:0]    m_ir;
    logic [AW-1:0] m_addr;
    logic          m_w;

    datapath_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset), .DIN(din),
        .IR_in(ir_in), .ADDR_in(addr_in), .DOUT_in(dout_in), .W_D(w_d),
        .G_in(g_in), .A_in(a_in), .incr_PC(incr_pc), .PC_in(pc_in),
        .mux_control(mux_control), .ULA_control(ula_control),
        .register_in(register_in), .register_out(register_out),
        .IR(ir), .G_or(g_or), .ADDR(addr), .DOUT(dout), .W(w), .bus(bus)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_pc = '0; m_a = '0; m_g = '0; m_dout = '0;
        m_ir = '0; m_addr = '0; m_w = 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_bus(input logic [1:0] sel, input logic [2:0] idx);
        case (sel)
            2'd0:    return din;
            2'd1:    return m_r[idx];
            2'd2:    return m_pc;
            default: return m_g;
        endcase
    endfunction

    function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] x,
                                              input logic [DW-1:0] y);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            4'd5:    return x + y;
            4'd6:    return x - y;
            4'd7:    return x | y;
            4'd8:    return (sx < sy) ? DW'(1) : DW'(0);
            4'd9:    return x << y[3:0];
            4'd10:   return x >> y[3:0];
            default: return y;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Driver: apply one step of strobes after the falling edge, advance the model, queue outputs.
    task automatic step(input stim_t s);
        logic [DW-1:0] b;
        @(negedge clock);
        din = s.din; ir_in = s.ir_in; addr_in = s.addr_in; dout_in = s.dout_in;
        w_d = s.w_d; g_in = s.g_in; a_in = s.a_in; incr_pc = s.incr_pc; pc_in = s.pc_in;
        mux_control = s.mux; ula_control = s.ula;
        register_in = s.rin; register_out = s.rout;
        b = model_bus(s.mux, s.rout);
        if (s.g_in)    m_g = alu_ref(s.ula, m_a, b);
        for (int i = 0; i < 7; i++) if (s.rin[i]) m_r[i] = b;
        if (s.pc_in)        m_pc = b;
        else if (s.incr_pc) m_pc = m_pc + 1'b1;
        if (s.ir_in)   m_ir = s.din[9:0];
        if (s.a_in)    m_a = b;
        if (s.addr_in) m_addr = b[AW-1:0];
        if (s.dout_in) m_dout = b;
        m_w = s.w_d;
        exp_q.push_back({m_ir, (m_g != 0), m_addr, m_dout, m_w, model_bus(s.mux, s.rout)});
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    task automatic load_reg(input int idx, input logic [DW-1:0] v);
        stim_t s;
        s = idle(); s.din = v; s.rin = 7'(1 << idx);
        step(s);
    endtask

    task automatic alu_op(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [3:0] op);
        stim_t s;
        s = idle(); s.din = av; s.a_in = 1'b1;
        step(s);
        s = idle(); s.din = bv; s.g_in = 1'b1; s.ula = op;
        step(s);
        s = idle(); s.mux = 2'd3;
        step(s);
        settle();
    endtask

    // Monitor: every rising edge presents a new output set; pop and compare.
    always @(posedge clock) begin
        logic [EXP_W-1:0] e, a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ir, g_or, addr, dout, w, bus};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got ir=%h g_or=%b addr=%h dout=%h w=%b bus=%h expected ir=%h g_or=%b addr=%h dout=%h w=%b bus=%h",
                         $time, a[EXP_W-1 -: 10], a[EXP_W-11], a[EXP_W-12 -: AW],
                         a[DW+DW:DW+1], a[DW], a[DW-1:0],
                         e[EXP_W-1 -: 10], e[EXP_W-11], e[EXP_W-12 -: AW],
                         e[DW+DW:DW+1], e[DW], e[DW-1:0]);
            end
        end
    end

    initial begin
        stim_t s;
        int wait_cycles;

        reset = 1'b1;
        din = '0; ir_in = 0; addr_in = 0; dout_in = 0; w_d = 0; g_in = 0; a_in = 0;
        incr_pc = 0; pc_in = 0; mux_control = '0; ula_control = '0;
        register_in = '0; register_out = '0;
        model_reset();
        #1;
        check("reset_outputs", {ir, g_or, addr, dout, w}, '0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Fetch: bring PC to 3, then fetch with increment, then PC_in beating incr_PC.
        repeat (3) begin
            s = idle(); s.incr_pc = 1'b1;
            step(s);
        end
        s = idle(); s.din = 16'h0158; s.ir_in = 1'b1; s.incr_pc = 1'b1; s.mux = 2'd2;
        step(s);
        settle();
        check("fetch_ir", 32'(ir), 32'h158);
        check("fetch_pc", 32'(bus), 32'h0004);
        s = idle(); s.din = 16'h0020; s.pc_in = 1'b1; s.incr_pc = 1'b1;
        step(s);
        s = idle(); s.mux = 2'd2;
        step(s);
        settle();
        check("pc_in_priority", 32'(bus), 32'h0020);

        // ADD with signed overflow written back to R1.
        load_reg(1, 16'h7FFF);
        load_reg(2, 16'h0001);
        s = idle(); s.mux = 2'd1; s.rout = 3'd1; s.a_in = 1'b1;
        step(s);
        s = idle(); s.mux = 2'd1; s.rout = 3'd2; s.g_in = 1'b1; s.ula = 4'b0101;
        step(s);
        s = idle(); s.mux = 2'd3; s.rin = 7'b0000010;
        step(s);
        s = idle(); s.mux = 2'd1; s.rout = 3'd1;
        step(s);
        settle();
        check("add_r1", 32'(bus), 32'h8000);
        check("add_g_or", 32'(g_or), 32'h1);

        alu_op(16'h0005, 16'h0005, 4'b0110);
        check("sub_zero_g", 32'(bus), 32'h0000);
        check("sub_zero_g_or", 32'(g_or), 32'h0);
        alu_op(16'hFFFF, 16'h0001, 4'b1000);
        check("slt_signed", 32'(bus), 32'h0001);
        alu_op(16'h0001, 16'h0013, 4'b1001);
        check("sll_low_nibble", 32'(bus), 32'h0008);
        alu_op(16'h8000, 16'h000F, 4'b1010);
        check("srl_logical", 32'(bus), 32'h0001);

        // Store path.
        load_reg(3, 16'h01A5);
        load_reg(4, 16'h1234);
        s = idle(); s.mux = 2'd1; s.rout = 3'd3; s.addr_in = 1'b1;
        step(s);
        settle();
        check("store_addr", 32'(addr), 32'hA5);
        s = idle(); s.mux = 2'd1; s.rout = 3'd4; s.dout_in = 1'b1; s.w_d = 1'b1;
        step(s);
        settle();
        check("store_dout", 32'(dout), 32'h1234);
        check("store_w", 32'(w), 32'h1);
        s = idle(); s.mux = 2'd1; s.rout = 3'd7;
        step(s);
        settle();
        check("r7_reads_zero", 32'(bus), 32'h0);
        check("w_drops", 32'(w), 32'h0);

        // Reset arriving while an ADD producing 9 is pending on the next edge.
        s = idle(); s.din = 16'h0004; s.a_in = 1'b1;
        step(s);
        @(negedge clock);
        din = 16'h0005; g_in = 1'b1; ula_control = 4'b0101; mux_control = 2'd0;
        a_in = 1'b0; register_in = '0;
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_regs", {ir, addr, dout, w}, '0);
        check("midrun_reset_g_or", 32'(g_or), 32'h0);
        @(posedge clock);
        #2;
        check("reset_held_g_or", 32'(g_or), 32'h0);
        reset = 1'b0;
        g_in = 1'b0;
        model_reset();
        s = idle(); s.mux = 2'd3;
        step(s);
        s = idle(); s.mux = 2'd2;
        step(s);

        // Random strobes across all controls.
        for (int n = 0; n < 400; n++) begin
            s.din     = DW'($urandom);
            s.ir_in   = 1'($urandom_range(0, 1));
            s.addr_in = 1'($urandom_range(0, 1));
            s.dout_in = 1'($urandom_range(0, 1));
            s.w_d     = 1'($urandom_range(0, 1));
            s.g_in    = 1'($urandom_range(0, 1));
            s.a_in    = 1'($urandom_range(0, 1));
            s.incr_pc = 1'($urandom_range(0, 1));
            s.pc_in   = ($urandom_range(0, 7) == 0);
            s.mux     = 2'($urandom_range(0, 3));
            s.ula     = 4'($urandom_range(0, 15));
            s.rin     = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            s.rout    = 3'($urandom_range(0, 7));
            step(s);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clock);
            wait_cycles++;
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Multi-cycle processor datapath, directly downstream of the control FSM; consumes every control strobe the FSM emits each step.
- Holds the register file R0..R6, PC, instruction register, ALU operand A, ALU result G, the memory address register and the data-out register.
- Drives a single shared bus through a 4:1 mux.
- Returns IR[9:0] and the G-nonzero flag to the control FSM.

Parameters:
DATA_W, 16, width of bus, registers, PC, A, G, DIN, DOUT
ADDR_W, 8, width of ADDR output (ADDR = bus[ADDR_W-1:0])

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
DIN  in  DATA_W  memory read data
IR_in  in  1  load IR from DIN[9:0]
ADDR_in  in  1  load ADDR from bus
DOUT_in  in  1  load DOUT from bus
W_D  in  1  memory write request, registered to W
G_in  in  1  load G from ALU result
A_in  in  1  load A from bus
incr_PC  in  1  PC <= PC+1
PC_in  in  1  PC <= bus
mux_control  in  2  bus select: 00 DIN, 01 R[register_out], 10 PC, 11 G
ULA_control  in  4  ALU operation code
register_in  in  7  one-hot-or-multi write enables for R0..R6
register_out  in  3  register read select
IR  out  10  instruction register to control FSM
G_or  out  1  OR-reduction of G (1 when G != 0)
ADDR  out  ADDR_W  memory address register
DOUT  out  DATA_W  memory write data register
W  out  1  registered memory write enable
bus  out  DATA_W  current bus value (debug/observation)

Behaviour:
- Reset (async, any time, including mid-instruction): R0..R6, PC, IR, A, G, ADDR, DOUT, W all 0 immediately. G_or=0. bus then reflects the mux on the reset-time inputs.
- Bus is combinational from mux_control.
  - register_out=7 (no R7) reads 0.
- ALU is combinational, A op B, B = bus:
  - 0101 ADD: A+B mod 2^DATA_W.
  - 0110 SUB: A-B mod 2^DATA_W.
  - 0111 OR: A|B.
  - 1000 SLT: 1 if signed A < signed B else 0.
  - 1001 SLL: A << B[3:0].
  - 1010 SRL: A >> B[3:0], logical, zero fill.
  - Any other code yields B.
- G loads the ALU result when G_in=1, otherwise holds. G_or is a combinational OR of the G register.
- Register file: each R[i] with register_in[i]=1 loads bus on the clock edge. Multiple bits set write the same value to all selected registers.
- Same-edge read/write: register reads return the pre-edge value; a register written and read in the same step sees the old value on bus.
- PC priority: PC_in beats incr_PC. PC wraps 2^DATA_W-1 -> 0.
- IR loads DIN[9:0] when IR_in=1.
- A, ADDR and DOUT load when their strobe is 1; ADDR takes bus[ADDR_W-1:0].
- W <= W_D every edge, so W is asserted in the cycle after the strobe, aligned with the newly loaded DOUT/ADDR. There is one-cycle latency on all registered outputs.
- All strobes are independent. Any combination in one cycle updates each target from the same pre-edge bus value.
- No hidden state beyond the listed registers. All holds are explicit (no strobe means no change).

Test Plan:
- Reset then reset pulse mid-ADD step 3 (G=0x0009 pending) -> IR, PC, R0..R6, A, G, ADDR, DOUT, W all 0 asynchronously; G_or=0.
- Fetch: DIN=0x0158, IR_in=1, incr_PC=1 from PC=0x0003 -> IR=0x158, PC=0x0004; same edge with PC_in=1 and bus=0x0020 -> PC=0x0020.
- ADD: R1=0x7FFF, R2=0x0001; A_in with out=R1, then G_in ULA=0101 out=R2, then register_in=0000010 mux=11 -> R1=0x8000, G_or=1.
- SUB to zero: A=5, B=5, ULA=0110 -> G=0, G_or=0.
- SLT: A=0xFFFF, B=0x0001 -> G=1.
- Shift boundaries: SLL A=0x0001 with B=0x0013 -> G=0x0008 (only B[3:0] used). SRL A=0x8000 with B=0x000F -> G=0x0001.
- Store path: ADDR_in with bus=R3=0x01A5 -> ADDR=0xA5; next cycle DOUT_in and W_D with R4=0x1234 -> DOUT=0x1234 and W=1 one cycle later; register_out=7 with mux=01 -> bus=0.
